// File: rtl/eta_err_recover_pkg.sv
// Shared constants and FSM state type for the ETA error-recovery block.
package eta_pkg;

    localparam int ETA_WIDTH       = 32;
    localparam int ETA_APPROX_BITS = 20;
    localparam int ETA_CHUNK       = 4;
    localparam int ETA_NCHUNK      = ETA_APPROX_BITS / ETA_CHUNK;
    localparam int ETA_IDX_W       = $clog2(ETA_NCHUNK);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPROX = 3'd1,
        FIX    = 3'd2,
        UPPER  = 3'd3,
        DONE   = 3'd4
    } eta_state_e;

endpackage

// File: rtl/eta_err_recover_if.sv
// Operand/result handshake bundle between a producer/consumer and eta_err_recover.
interface eta_err_recover_if;
    import eta_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [ETA_WIDTH-1:0]   in_a;
    logic [ETA_WIDTH-1:0]   in_b;
    logic                   approx_valid;
    logic [ETA_WIDTH:0]     approx_sum;
    logic                   out_valid;
    logic                   out_ready;
    logic [ETA_WIDTH:0]     exact_sum;
    logic [ETA_WIDTH+1:0]   err;
    logic                   err_flag;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, approx_valid, approx_sum, out_valid, exact_sum, err, err_flag
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, approx_valid, approx_sum, out_valid, exact_sum, err, err_flag
    );

endinterface

// File: rtl/eta_err_recover_approx_core.sv
// Combinational ETA approximate adder: carry-free low field with a saturating
// control chain, exact adder on the high field with carry-in tied to zero.
module eta_approx_core
    import eta_pkg::*;
#(
    parameter int W  = ETA_WIDTH,
    parameter int AB = ETA_APPROX_BITS
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    logic [AB-1:0]   ctl;
    logic [AB-1:0]   low;
    logic [W-AB:0]   high;

    // Once a generate is seen, every lower bit is forced to one.
    always_comb begin
        ctl = '0;
        ctl[AB-1] = a[AB-1] & b[AB-1];
        for (int i = AB - 2; i >= 0; i--) begin
            ctl[i] = ctl[i+1] | (a[i] & b[i]);
        end
    end

    assign low  = ctl | (a[AB-1:0] ^ b[AB-1:0]);
    assign high = {1'b0, a[W-1:AB]} + {1'b0, b[W-1:AB]};
    assign sum  = {high, low};

endmodule

// File: rtl/eta_err_recover.sv
// Publishes the ETA approximate sum early, then rebuilds the exact sum chunk by
// chunk and reports exact-approx. Optional stats counters: ETA_ERR_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for an operand pair (only state with in_ready)
// APPROX | approx_sum valid pulse; carry/chunk index cleared
// FIX    | ripple one CHUNK-bit slice of the low field per cycle
// UPPER  | add high field with final carry, compute error
// DONE   | result presented until out_ready
module eta_err_recover
    import eta_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    eta_err_recover_if.slave  bus
`ifdef ETA_ERR_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_errs
`endif
);

    localparam int W  = ETA_WIDTH;
    localparam int AB = ETA_APPROX_BITS;
    localparam int C  = ETA_CHUNK;
    localparam int NC = ETA_NCHUNK;
    localparam int HW = W - AB;

    eta_state_e             state_q, state_d;
    logic [W-1:0]           a_q, b_q;
    logic                   carry_q;
    logic [ETA_IDX_W-1:0]   idx_q;
    logic [AB-1:0]          low_q;
    logic [W:0]             approx_d, approx_q, exact_q;
    logic [W+1:0]           err_q;
    logic                   err_flag_q;
    logic                   rdy_q;

    logic                   accept;
    logic                   handoff;
    logic                   approx_valid_c;
    logic                   out_valid_c;
    logic [C:0]             chunk_sum;
    logic [HW:0]            high_sum;
    logic [W:0]             exact_d;
    logic [W+1:0]           err_d;

    eta_approx_core #(
        .W  (W),
        .AB (AB)
    ) u_core (
        .a   (bus.in_a),
        .b   (bus.in_b),
        .sum (approx_d)
    );

    // rdy_q mirrors "state is IDLE" but stays low through reset.
    assign accept  = bus.in_valid & rdy_q;
    assign handoff = out_valid_c & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        approx_valid_c = 1'b0;
        out_valid_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = APPROX;
            end
            APPROX: begin
                approx_valid_c = 1'b1;
                state_d        = FIX;
            end
            FIX: begin
                if (idx_q == ETA_IDX_W'(NC - 1)) state_d = UPPER;
            end
            UPPER: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign chunk_sum = {1'b0, a_q[idx_q*C +: C]} + {1'b0, b_q[idx_q*C +: C]} + (C+1)'(carry_q);
    assign high_sum  = {1'b0, a_q[W-1:AB]} + {1'b0, b_q[W-1:AB]} + (HW+1)'(carry_q);
    assign exact_d   = {high_sum, low_q};
    assign err_d     = {1'b0, exact_d} - {1'b0, approx_q};

    // Low field accumulates in low_q so exact_sum keeps the previous result until UPPER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            low_q      <= '0;
            approx_q   <= '0;
            exact_q    <= '0;
            err_q      <= '0;
            err_flag_q <= 1'b0;
        end else begin
            rdy_q <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q      <= bus.in_a;
                        b_q      <= bus.in_b;
                        approx_q <= approx_d;
                    end
                end
                APPROX: begin
                    carry_q <= 1'b0;
                    idx_q   <= '0;
                end
                FIX: begin
                    low_q[idx_q*C +: C] <= chunk_sum[C-1:0];
                    carry_q             <= chunk_sum[C];
                    idx_q               <= idx_q + 1'b1;
                end
                UPPER: begin
                    exact_q    <= exact_d;
                    err_q      <= err_d;
                    err_flag_q <= |err_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = rdy_q;
    assign bus.approx_valid = approx_valid_c;
    assign bus.approx_sum   = approx_q;
    assign bus.out_valid    = out_valid_c;
    assign bus.exact_sum    = exact_q;
    assign bus.err          = err_q;
    assign bus.err_flag     = err_flag_q;

`ifdef ETA_ERR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (handoff) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (err_flag_q && (stat_errs != 16'hFFFF)) stat_errs <= stat_errs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eta_err_recover.sv
// Bench for eta_err_recover: spec-level model checked every cycle plus directed
// literal vectors. Build with ETA_ERR_STATS_EN to cover the stats counters.
module tb_eta_err_recover;
    import eta_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eta_err_recover_if bus();

`ifdef ETA_ERR_STATS_EN
    logic [15:0] stat_ops, stat_errs;
`endif

    eta_err_recover dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ETA_ERR_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Approximate sum from the ETA rule: below the highest generate in the low
    // field every bit is one, above it the bits are plain XOR; high field adds.
    function automatic logic [32:0] approx_model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] g, low, high;
        g    = 64'(a & b) & 64'hFFFFF;
        low  = 64'(a ^ b) & 64'hFFFFF;
        for (int p = 19; p >= 0; p--) begin
            if (g[p]) begin
                low = low | ((64'd1 << (p + 1)) - 64'd1);
                break;
            end
        end
        high = 64'(a >> 20) + 64'(b >> 20);
        return 33'((high << 20) | low);
    endfunction

    // Model: t counts cycles since accept (0 idle, 1 approx pulse, 8 done).
    int          t;
    bit          m_rdy;
    logic [31:0] ma, mb;
    logic [32:0] m_approx, m_exact;
    logic [33:0] m_err;
    bit          m_flag;
    int          m_ops, m_errs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; m_rdy = 0; ma = 0; mb = 0;
            m_approx = 0; m_exact = 0; m_err = 0; m_flag = 0;
            m_ops = 0; m_errs = 0;
        end else begin
            if (t == 0) begin
                if (m_rdy && bus.in_valid) begin
                    ma = bus.in_a; mb = bus.in_b;
                    m_approx = approx_model(ma, mb);
                    t = 1;
                end
            end else if (t < 8) begin
                t++;
                if (t == 8) begin
                    m_exact = 33'(64'(ma) + 64'(mb));
                    m_err   = 34'({1'b0, m_exact}) - 34'({1'b0, m_approx});
                    m_flag  = (m_err != 0);
                end
            end else if (bus.out_ready) begin
                if (m_ops < 65535) m_ops++;
                if (m_flag && m_errs < 65535) m_errs++;
                t = 0;
            end
            m_rdy = (t == 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_in_ready", 64'(bus.in_ready), 64'(m_rdy));
            chk("cmp_approx_valid", 64'(bus.approx_valid), 64'(t == 1));
            chk("cmp_out_valid", 64'(bus.out_valid), 64'(t == 8));
            chk("cmp_approx_sum", 64'(bus.approx_sum), 64'(m_approx));
            chk("cmp_exact_sum", 64'(bus.exact_sum), 64'(m_exact));
            chk("cmp_err", 64'(bus.err), 64'(m_err));
            chk("cmp_err_flag", 64'(bus.err_flag), 64'(m_flag));
`ifdef ETA_ERR_STATS_EN
            chk("cmp_stat_ops", 64'(stat_ops), 64'(m_ops));
            chk("cmp_stat_errs", 64'(stat_errs), 64'(m_errs));
`endif
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [32:0] ea,
                         input logic [32:0] ee, input logic [33:0] er, input int hold);
        int n;
        wait_ready();
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("lit_approx_valid", 64'(bus.approx_valid), 64'd1);
        chk("lit_approx_sum", 64'(bus.approx_sum), 64'(ea));
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("lit_latency", 64'(n), 64'd8);
        chk("lit_exact_sum", 64'(bus.exact_sum), 64'(ee));
        chk("lit_err", 64'(bus.err), 64'(er));
        chk("lit_err_flag", 64'(bus.err_flag), 64'(er != 0));
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_exact_sum", 64'(bus.exact_sum), 64'(ee));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_exact_held", 64'(bus.exact_sum), 64'(ee));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_approx_valid"}, 64'(bus.approx_valid), 64'd0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_approx_sum"}, 64'(bus.approx_sum), 64'd0);
        chk({tag, "_exact_sum"}, 64'(bus.exact_sum), 64'd0);
        chk({tag, "_err"}, 64'(bus.err), 64'd0);
        chk({tag, "_err_flag"}, 64'(bus.err_flag), 64'd0);
`ifdef ETA_ERR_STATS_EN
        chk({tag, "_stat_ops"}, 64'(stat_ops), 64'd0);
        chk({tag, "_stat_errs"}, 64'(stat_errs), 64'd0);
`endif
    endtask

    logic [31:0] va [6] = '{32'h12345678, 32'h00000011, 32'hFFFFFFFF, 32'h0, 32'h000FFFFF, 32'hABCDE000};
    logic [31:0] vb [6] = '{32'h9ABCDEF0, 32'h00000011, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'h00012345};

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        #1;
        chk_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(32'h0000000F, 32'h00000001, 33'h00000000F, 33'h000000010, 34'd1, 0);
        do_op(32'h00080000, 32'h00080000, 33'h0000FFFFF, 33'h000100000, 34'd1, 0);
        do_op(32'h00100000, 32'h00100000, 33'h000200000, 33'h000200000, 34'd0, 0);
        do_op(32'hFFFFFFFF, 32'h00000001, 33'h0FFFFFFFF, 33'h100000000, 34'd1, 10);

        // Further patterns checked by the model only.
        for (int i = 0; i < 6; i++) begin
            wait_ready();
            bus.in_valid = 1'b1; bus.in_a = va[i]; bus.in_b = vb[i];
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            repeat (9) @(posedge clk);
            #1 bus.out_ready = 1'b1;
            @(posedge clk); #1 bus.out_ready = 1'b0;
        end

        // Back-to-back with in_valid held high: operands change while busy.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 32'h01234567 * (i + 1);
            bus.in_b = 32'h89ABCDEF ^ (32'(i) << 13);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // Reset during FIX aborts the op and clears everything.
        wait_ready();
        bus.in_valid = 1'b1; bus.in_a = 32'h0000FFFF; bus.in_b = 32'h00000001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_zero("midfix_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(32'h0000000F, 32'h00000001, 33'h00000000F, 33'h000000010, 34'd1, 0);
`ifdef ETA_ERR_STATS_EN
        chk("stat_ops_after_reset", 64'(stat_ops), 64'd1);
        chk("stat_errs_after_reset", 64'(stat_errs), 64'd1);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
